// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared shift-add multiplier.
// It grants one requester, sequences the multiplier handshake and returns the product, or flags an error on timeout.
module mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start,
  input  logic                 mul_ready,
  input  logic [2*WIDTH-1:0]   mul_product
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, CLEAR_WAIT, LAUNCH, RUN, RESPOND
  } state_t;

  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 ptr_q, ptr_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    logic pick;
    pick    = 1'b0;
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // ptr_q names the requester that wins a tie; it flips away from whoever is granted.
          pick    = (req0 && req1) ? ptr_q : req1;
          gnt_d   = pick;
          ptr_d   = ~pick;
          opa_d   = pick ? a1 : a0;
          opb_d   = pick ? b1 : b0;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = mul_ready ? CLEAR : LAUNCH;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (!mul_ready) begin
          state_d = LAUNCH;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (mul_ready) begin
          res_d   = mul_product;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mul_start = (state_q == CLEAR) || (state_q == LAUNCH);
  assign mul_a     = opa_q;
  assign mul_b     = opb_q;
  assign done0     = (state_q == RESPOND) && !gnt_q;
  assign done1     = (state_q == RESPOND) &&  gnt_q;
  assign result    = (state_q == RESPOND) ? res_q : '0;
  assign err       = (state_q == RESPOND) && err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural shift-add multiplier model plus an in-order result scoreboard.
module tb_mult_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           done0, done1, err, busy, mul_start;
  logic [2*W-1:0] result;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_ready;
  logic [2*W-1:0] mul_product;

  mult_arbiter #(.WIDTH(W), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: START while READY returns it to idle, START while idle begins a multiply.
  logic           m_preset = 1'b0;
  logic           m_hang = 1'b0;
  int             m_lat = 3;
  logic           m_busy;
  int             m_cnt;
  logic [W-1:0]   m_pa, m_pb;
  always @(posedge clk) begin
    if (reset) begin
      mul_ready <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; mul_product <= '0;
    end else if (m_preset) begin
      mul_ready <= 1'b1; m_busy <= 1'b0; mul_product <= 16'hDEAD;
    end else if (mul_start) begin
      if (mul_ready) mul_ready <= 1'b0;
      else begin
        m_busy <= 1'b1; m_cnt <= m_lat; m_pa <= mul_a; m_pb <= mul_b;
      end
    end else if (m_busy && !m_hang) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0; mul_ready <= 1'b1; mul_product <= m_pa * m_pb;
      end else m_cnt <= m_cnt - 1;
    end
  end

  typedef struct { logic id; logic [2*W-1:0] res; logic err; } exp_t;
  exp_t sb[$];

  int   start_cnt = 0;
  logic start_rdy[$];
  int   start_cyc[$];
  logic [W-1:0] start_a, start_b;

  always @(negedge clk) begin
    if (mul_start === 1'b1) begin
      start_cnt++;
      start_rdy.push_back(mul_ready);
      start_cyc.push_back(cyc);
      start_a = mul_a;
      start_b = mul_b;
    end
  end

  // Scoreboard: every done pulse is matched against the oldest expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (done0 === 1'b1 || done1 === 1'b1)) begin
      n_cmp++;
      if (done0 && done1) begin
        n_err++;
        $display("FAIL done_exclusive: got done0=1 done1=1, want one at a time");
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got done%0d res=%0d err=%0b, want no done", done1, result, err);
      end else begin
        e = sb.pop_front();
        if ({done1, result, err} !== {e.id, e.res, e.err}) begin
          n_err++;
          $display("FAIL sb_result: got id=%0d res=%0d err=%0b, want id=%0d res=%0d err=%0b",
                   done1, result, err, e.id, e.res, e.err);
        end else
          $display("txn: done%0d result=%0d err=%0b ok", done1, result, err);
      end
    end
  end

  task automatic push_exp(input logic id, input logic [2*W-1:0] res, input logic e);
    exp_t x;
    x.id = id; x.res = res; x.err = e;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input logic id);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = id ? done1 : done0;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done%0d: got no done pulse, want one within 300 cycles", id);
    end
  endtask

  task automatic test_reset();
    @(negedge clk) begin reset = 1'b1; req0 = 1'b1; a0 = 8'd3; b0 = 8'd3; end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done0, done1, mul_start, err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b done0=%b done1=%b start=%b err=%b, want all 0",
               busy, done0, done1, mul_start, err);
    end
    n_cmp++;
    if ({result, mul_a, mul_b} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: got result=%0d mul_a=%0d mul_b=%0d, want 0", result, mul_a, mul_b);
    end
    req0 = 1'b0;
    reset = 1'b0;
    $display("txn: reset checked");
  endtask

  task automatic test_basic();
    start_cnt = 0;
    m_lat = 3;
    @(negedge clk) begin req0 = 1'b1; a0 = 8'd13; b0 = 8'd11; end
    push_exp(1'b0, 16'd143, 1'b0);
    wait_done(1'b0);
    req0 = 1'b0;
    n_cmp++;
    if (start_cnt !== 1) begin
      n_err++;
      $display("FAIL basic_starts: got %0d mul_start pulses, want 1", start_cnt);
    end
    n_cmp++;
    if ({start_a, start_b} !== {8'd13, 8'd11}) begin
      n_err++;
      $display("FAIL basic_operands: got mul_a=%0d mul_b=%0d, want 13 11", start_a, start_b);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m_lat = 2;
    @(negedge clk) begin
      req0 = 1'b1; a0 = 8'd3; b0 = 8'd4;
      req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
    end
    push_exp(1'b0, 16'd12, 1'b0);
    push_exp(1'b1, 16'd30, 1'b0);
    wait_done(1'b0);
    // req0 comes straight back while req1 is still waiting: req1 must win this tie.
    a0 = 8'd7; b0 = 8'd8;
    push_exp(1'b0, 16'd56, 1'b0);
    wait_done(1'b1);
    req1 = 1'b0;
    wait_done(1'b0);
    req0 = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    @(negedge clk) m_preset = 1'b1;
    @(negedge clk) m_preset = 1'b0;
    start_cnt = 0;
    start_rdy.delete();
    start_cyc.delete();
    m_lat = 4;
    @(negedge clk) begin req1 = 1'b1; a1 = 8'd255; b1 = 8'd255; end
    push_exp(1'b1, 16'd65025, 1'b0);
    wait_done(1'b1);
    req1 = 1'b0;
    n_cmp++;
    if (start_cnt !== 2) begin
      n_err++;
      $display("FAIL clear_starts: got %0d mul_start pulses, want 2", start_cnt);
    end
    n_cmp++;
    if (start_cyc.size() != 2) begin
      n_err++;
      $display("FAIL clear_gap: got %0d start pulses logged, want 2", start_cyc.size());
    end else if (start_rdy[0] !== 1'b1 || start_rdy[1] !== 1'b0 || start_cyc[1] - start_cyc[0] < 2) begin
      n_err++;
      $display("FAIL clear_gap: got ready=%b,%b gap=%0d, want ready=1,0 gap>=2",
               start_rdy[0], start_rdy[1], start_cyc[1] - start_cyc[0]);
    end
  endtask

  task automatic test_operand_change();
    int bad = 0;
    bit seen = 1'b0;
    start_cnt = 0;
    m_lat = 8;
    @(negedge clk) begin req0 = 1'b1; a0 = 8'd5; b0 = 8'd7; end
    push_exp(1'b0, 16'd35, 1'b0);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (start_cnt >= 2) a0 = 8'd9;
      if (busy && mul_a !== 8'd5) bad++;
      seen = done0;
    end
    req0 = 1'b0;
    n_cmp++;
    if (!seen || bad != 0) begin
      n_err++;
      $display("FAIL operand_hold: got done=%b mul_a changes=%0d, want done=1 changes=0", seen, bad);
    end
  endtask

  task automatic test_timeout();
    int run = 0;
    bit seen = 1'b0;
    do_reset();
    m_hang = 1'b1;
    m_lat = 3;
    @(negedge clk) begin req0 = 1'b1; a0 = 8'd2; b0 = 8'd3; end
    push_exp(1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mul_start;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done0;
      if (!seen) run++;
    end
    req0 = 1'b0;
    n_cmp++;
    if (!seen || run != 63) begin
      n_err++;
      $display("FAIL timeout_len: got done=%b after %0d RUN cycles, want done=1 after 63", seen, run);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got busy=%b, want 0", busy);
    end
    m_hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    m_lat = 20;
    @(negedge clk) begin req0 = 1'b1; a0 = 8'd4; b0 = 8'd4; end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mul_start;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, mul_start, done0, done1} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b start=%b done0=%b done1=%b, want all 0",
               busy, mul_start, done0, done1);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    m_lat = 3;
    req1 = 1'b1; a1 = 8'd6; b1 = 8'd7;
    push_exp(1'b1, 16'd42, 1'b0);
    wait_done(1'b1);
    req1 = 1'b0;
  endtask

  task automatic test_drain();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got %0d pending busy=%b, want 0 pending busy=0", sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_clear();
    test_operand_change();
    test_timeout();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
